// File: rtl/shift_link_rx.sv
// Serial LSB-first word receiver with a valid/ready word output and a sticky overflow flag.
// Optional even parity bit per frame when SHIFT_LINK_RX_PARITY_EN is defined.
module shift_link_rx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_valid,
  input  logic                  ser_data,
  input  logic                  ser_start,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_perr,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic                  busy
);
  // One extra counter value is needed to reach the parity bit position.
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic                  done;
  logic                  accept;

  assign sh_nxt = {ser_data, sh[DATA_WIDTH-1:1]};
  assign accept = !out_valid || out_ready;
  assign busy   = (state == RECV);

`ifdef SHIFT_LINK_RX_PARITY_EN
  logic perr;
  logic perr_q;

  always_comb begin
    done = 1'b0;
    word = sh;
    perr = ^{sh, ser_data};
    if (state == RECV && ser_valid && !ser_start)
      done = (cnt == CW'(DATA_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perr_q <= 1'b0;
    else if (done && accept)
      perr_q <= perr;
  end
  assign out_perr = perr_q;
`else
  always_comb begin
    done = 1'b0;
    word = sh_nxt;
    if (state == RECV && ser_valid && !ser_start)
      done = (cnt == CW'(DATA_WIDTH - 1));
  end
  assign out_perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ser_valid && (ser_start || state == RECV)) begin
`ifdef SHIFT_LINK_RX_PARITY_EN
        if (ser_start || cnt != CW'(DATA_WIDTH)) sh <= sh_nxt;
`else
        sh <= sh_nxt;
`endif
        if (ser_start) begin
          state <= RECV;
          cnt   <= CW'(1);
        end else if (done) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      if (done) begin
        if (accept) begin
          out_data  <= word;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // A drop on the same edge as clr_ovf wins.
      if (done && !accept)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_link_rx.sv
// Directed bench for shift_link_rx (DATA_WIDTH=16); parity case runs when SHIFT_LINK_RX_PARITY_EN is defined.
module tb_shift_link_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_valid = 1'b0;
  logic        ser_data = 1'b0;
  logic        ser_start = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_perr;
  logic        overflow;
  logic        clr_ovf = 1'b0;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  shift_link_rx #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_start(ser_start), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_perr(out_perr), .overflow(overflow),
    .clr_ovf(clr_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int gap, input bit start);
    for (int i = 0; i < n; i++) begin
      ser_valid = 1'b1;
      ser_start = start && (i == 0);
      ser_data  = v[i];
      tick();
      ser_valid = 1'b0;
      ser_start = 1'b0;
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input int gap, input bit par);
`ifdef SHIFT_LINK_RX_PARITY_EN
    send_bits({15'b0, par, w}, 17, gap, 1'b1);
`else
    if (par) ; // parity bit unused without parity support
    send_bits({16'b0, w}, 16, gap, 1'b1);
`endif
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_data", {16'b0, out_data}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_perr", {31'b0, out_perr}, 0);
    rst = 1'b0;
    tick();

    // Basic full-rate frame
    send_bits(32'h1, 1, 0, 1'b1);
    chk("busy_mid", {31'b0, busy}, 1);
    chk("valid_mid", {31'b0, out_valid}, 0);
    send_frame(16'hA5C3, 0, ^16'hA5C3);
    chk("basic_valid", {31'b0, out_valid}, 1);
    chk("basic_data", {16'b0, out_data}, 32'hA5C3);
    chk("basic_busy", {31'b0, busy}, 0);
    chk("basic_perr", {31'b0, out_perr}, 0);
    consume();
    chk("basic_drop", {31'b0, out_valid}, 0);
    chk("basic_hold", {16'b0, out_data}, 32'hA5C3);

    // Gapped strobes
    send_frame(16'h1234, 3, ^16'h1234);
    chk("gap_valid", {31'b0, out_valid}, 1);
    chk("gap_data", {16'b0, out_data}, 32'h1234);
    consume();
    repeat (5) tick();
    chk("gap_noextra", {31'b0, out_valid}, 0);

    // Mid-frame restart after 7 bits
    send_bits(32'h5A, 7, 0, 1'b1);
    send_frame(16'h00FF, 0, ^16'h00FF);
    chk("rs_valid", {31'b0, out_valid}, 1);
    chk("rs_data", {16'b0, out_data}, 32'h00FF);
    chk("rs_ovf", {31'b0, overflow}, 0);
    consume();
    repeat (3) tick();
    chk("rs_single", {31'b0, out_valid}, 0);

    // Overflow and clear
    send_frame(16'h1111, 0, ^16'h1111);
    send_frame(16'h2222, 0, ^16'h2222);
    chk("ov_data", {16'b0, out_data}, 32'h1111);
    chk("ov_flag", {31'b0, overflow}, 1);
    chk("ov_valid", {31'b0, out_valid}, 1);
    tick();
    chk("ov_sticky", {31'b0, overflow}, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ov_clr", {31'b0, overflow}, 0);
    consume();
    chk("ov_drop", {31'b0, out_valid}, 0);
    chk("ov_hold", {16'b0, out_data}, 32'h1111);

    // Back-to-back full-rate frames with ready held high
    out_ready = 1'b1;
    send_frame(16'h0F0F, 0, ^16'h0F0F);
    chk("b2b_first", {16'b0, out_data}, 32'h0F0F);
    send_frame(16'hF0F0, 0, ^16'hF0F0);
    chk("b2b_valid", {31'b0, out_valid}, 1);
    chk("b2b_data", {16'b0, out_data}, 32'hF0F0);
    chk("b2b_ovf", {31'b0, overflow}, 0);
    tick();
    out_ready = 1'b0;
    chk("b2b_drop", {31'b0, out_valid}, 0);

`ifdef SHIFT_LINK_RX_PARITY_EN
    send_frame(16'h0001, 0, 1'b1);
    chk("par_ok", {31'b0, out_perr}, 0);
    chk("par_ok_data", {16'b0, out_data}, 32'h0001);
    consume();
    send_frame(16'h0001, 0, 1'b0);
    chk("par_err", {31'b0, out_perr}, 1);
    consume();
`endif

    // Reset mid-frame
    send_bits(32'h1FF, 9, 0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", {31'b0, out_valid}, 0);
    chk("mr_busy", {31'b0, busy}, 0);
    chk("mr_data", {16'b0, out_data}, 0);
    send_bits(32'h1, 1, 0, 1'b0);
    chk("mr_ignored", {31'b0, busy}, 0);
    send_frame(16'hBEEF, 0, ^16'hBEEF);
    chk("mr_fvalid", {31'b0, out_valid}, 1);
    chk("mr_fdata", {16'b0, out_data}, 32'hBEEF);
    chk("mr_ovf", {31'b0, overflow}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
